// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             div_by_zero;

   // control unit side: issues requests, consumes results
   modport master (
      output start, x, y,
      input  busy, done, q, r, div_by_zero
   );

   // divider side
   modport slave (
      input  start, x, y,
      output busy, done, q, r, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed restoring divider (quotient to LO, remainder to HI)
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_divider_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_SIGN = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic             x_neg;
   logic             y_neg;
   logic             zero_div;
   logic [WIDTH-1:0] mag_y;
   logic [WIDTH-1:0] dvd;      // shifts out dividend bits, shifts in quotient bits
   logic [WIDTH-1:0] rem;      // partial remainder, always < |y| during CALC
   logic             done_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] r_q;
   logic             dbz_q;

   // Unsigned magnitudes fit in WIDTH bits: |-2^(WIDTH-1)| is 2^(WIDTH-1) read as unsigned.
   logic [WIDTH-1:0] x_mag;
   logic [WIDTH-1:0] y_mag;
   assign x_mag = bus.x[WIDTH-1] ? -bus.x : bus.x;
   assign y_mag = bus.y[WIDTH-1] ? -bus.y : bus.y;

   // One restoring step: shift {rem, dvd} left, trial-subtract |y| one bit wider to see the borrow.
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;
   assign rem_sh = {rem, dvd[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, mag_y};

   // Sign fix applied in SIGN: quotient negative on differing signs, remainder follows dividend.
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   assign q_fix = (x_neg ^ y_neg) ? -dvd : dvd;
   assign r_fix = x_neg ? -rem : rem;

   // Control FSM, datapath iteration and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         count    <= '0;
         x_neg    <= 1'b0;
         y_neg    <= 1'b0;
         zero_div <= 1'b0;
         mag_y    <= '0;
         dvd      <= '0;
         rem      <= '0;
         done_q   <= 1'b0;
         q_q      <= '0;
         r_q      <= '0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  x_neg    <= bus.x[WIDTH-1];
                  y_neg    <= bus.y[WIDTH-1];
                  mag_y    <= y_mag;
                  count    <= '0;
                  zero_div <= (bus.y == '0);
                  if (bus.y == '0) begin
                     // park |x| in rem so the normal sign fix reproduces x as the remainder
                     rem   <= x_mag;
                     dvd   <= '0;
                     state <= ST_SIGN;
                  end else begin
                     rem   <= '0;
                     dvd   <= x_mag;
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (trial[WIDTH]) begin
                  rem <= rem_sh[WIDTH-1:0];
               end else begin
                  rem <= trial[WIDTH-1:0];
               end
               dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
               count <= count + CNT_W'(1);
               if (count == CNT_W'(WIDTH - 1)) begin
                  state <= ST_SIGN;
               end
            end
            ST_SIGN: begin
               q_q    <= zero_div ? '1 : q_fix;
               r_q    <= r_fix;
               dbz_q  <= zero_div;
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = (state != ST_IDLE);
   assign bus.done        = done_q;
   assign bus.q           = q_q;
   assign bus.r           = r_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider (WIDTH=32 and WIDTH=8)
module tb_seq_divider;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   seq_divider_if #(.WIDTH(32)) b32 ();
   seq_divider_if #(.WIDTH(8))  b8 ();

   seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

   always #5 clk = ~clk;

   // truncating signed division reference, plain arithmetic
   function automatic void ref32(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] q, output logic [31:0] r);
      longint xs, ys, qs, rs;
      xs = longint'($signed(x));
      ys = longint'($signed(y));
      if (ys == 0) begin
         q = '1;
         r = x;
      end else begin
         qs = xs / ys;
         rs = xs % ys;
         q  = qs[31:0];
         r  = rs[31:0];
      end
   endfunction

   function automatic void ref8(input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] q, output logic [7:0] r);
      int xs, ys, qs, rs;
      xs = $signed(x);
      ys = $signed(y);
      if (ys == 0) begin
         q = '1;
         r = x;
      end else begin
         qs = xs / ys;
         rs = xs % ys;
         q  = qs[7:0];
         r  = rs[7:0];
      end
   endfunction

   // drive a one-cycle start from the current negedge; operands scrambled after acceptance
   task automatic launch_now32(input logic [31:0] x, input logic [31:0] y);
      b32.start = 1'b1;
      b32.x = x;
      b32.y = y;
      @(negedge clk);
      b32.start = 1'b0;
      b32.x = $urandom();
      b32.y = $urandom();
   endtask

   task automatic launch32(input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      launch_now32(x, y);
   endtask

   task automatic wait32(output int lat, output int busy_cnt);
      int n;
      n = 0;
      busy_cnt = (b32.busy === 1'b1) ? 1 : 0;
      while (b32.done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         if (b32.busy === 1'b1) busy_cnt++;
      end
      lat = n;
   endtask

   task automatic launch8(input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      b8.start = 1'b1;
      b8.x = x;
      b8.y = y;
      @(negedge clk);
      b8.start = 1'b0;
      b8.x = 8'($urandom());
      b8.y = 8'($urandom());
   endtask

   task automatic wait8(output int lat);
      int n;
      n = 0;
      while (b8.done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      lat = n;
   endtask

   task automatic test_reset();
      #1;
      vectors++; if (b32.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", b32.busy); end
      vectors++; if (b32.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", b32.done); end
      vectors++; if (b32.q !== 32'h0) begin miscompares++; $display("FAIL reset_q: got %h want 0", b32.q); end
      vectors++; if (b32.r !== 32'h0) begin miscompares++; $display("FAIL reset_r: got %h want 0", b32.r); end
      vectors++; if (b32.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b want 0", b32.div_by_zero); end
      vectors++; if (b8.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy8: got %b want 0", b8.busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bc;
      launch32(32'd100, 32'd7);
      wait32(lat, bc);
      vectors++; if (lat != 33) begin miscompares++; $display("FAIL basic_latency: got %0d want 33", lat); end
      vectors++; if (bc != 33) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want 33", bc); end
      vectors++; if (b32.q !== 32'd14) begin miscompares++; $display("FAIL basic_q: got %h want %h", b32.q, 32'd14); end
      vectors++; if (b32.r !== 32'd2) begin miscompares++; $display("FAIL basic_r: got %h want %h", b32.r, 32'd2); end
      vectors++; if (b32.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL basic_dbz: got %b want 0", b32.div_by_zero); end
      @(negedge clk);
      vectors++; if (b32.done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 0", b32.done); end
      vectors++; if (b32.q !== 32'd14) begin miscompares++; $display("FAIL basic_q_hold: got %h want %h", b32.q, 32'd14); end
   endtask

   task automatic test_signs();
      logic [31:0] xs [5] = '{-32'sd100, 32'd100, -32'sd100, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] ys [5] = '{32'd7, -32'sd7, -32'sd7, 32'hFFFF_FFFF, 32'd1};
      logic [31:0] eq, er;
      int lat, bc;
      for (int i = 0; i < 5; i++) begin
         ref32(xs[i], ys[i], eq, er);
         launch32(xs[i], ys[i]);
         wait32(lat, bc);
         vectors++; if (lat != 33) begin miscompares++; $display("FAIL signs_latency[%0d]: got %0d want 33", i, lat); end
         vectors++; if (b32.q !== eq) begin miscompares++; $display("FAIL signs_q[%0d]: got %h want %h", i, b32.q, eq); end
         vectors++; if (b32.r !== er) begin miscompares++; $display("FAIL signs_r[%0d]: got %h want %h", i, b32.r, er); end
         vectors++; if (b32.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL signs_dbz[%0d]: got %b want 0", i, b32.div_by_zero); end
      end
   endtask

   task automatic test_div_zero();
      int lat, bc;
      launch32(32'd1234, 32'd0);
      wait32(lat, bc);
      vectors++; if (lat != 1) begin miscompares++; $display("FAIL dbz_latency: got %0d want 1", lat); end
      vectors++; if (bc != 1) begin miscompares++; $display("FAIL dbz_busy_cycles: got %0d want 1", bc); end
      vectors++; if (b32.div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_flag: got %b want 1", b32.div_by_zero); end
      vectors++; if (b32.q !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dbz_q: got %h want ffffffff", b32.q); end
      vectors++; if (b32.r !== 32'd1234) begin miscompares++; $display("FAIL dbz_r: got %h want %h", b32.r, 32'd1234); end
      @(negedge clk);
      vectors++; if (b32.div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_flag_hold: got %b want 1", b32.div_by_zero); end
      launch32(32'd9, 32'd3);
      wait32(lat, bc);
      vectors++; if (lat != 33) begin miscompares++; $display("FAIL after_dbz_latency: got %0d want 33", lat); end
      vectors++; if (b32.q !== 32'd3) begin miscompares++; $display("FAIL after_dbz_q: got %h want 3", b32.q); end
      vectors++; if (b32.r !== 32'd0) begin miscompares++; $display("FAIL after_dbz_r: got %h want 0", b32.r); end
      vectors++; if (b32.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL after_dbz_flag: got %b want 0", b32.div_by_zero); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] eq, er;
      int lat, bc;
      launch32(32'd1000, 32'd3);
      wait32(lat, bc);
      vectors++; if (b32.q !== 32'd333 || b32.r !== 32'd1) begin miscompares++; $display("FAIL b2b_first: got q=%h r=%h want q=14d r=1", b32.q, b32.r); end
      launch_now32(-32'sd77, 32'd5);
      vectors++; if (b32.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy=%b want 1", b32.busy); end
      vectors++; if (b32.q !== 32'd333) begin miscompares++; $display("FAIL b2b_q_hold: got %h want %h", b32.q, 32'd333); end
      ref32(-32'sd77, 32'd5, eq, er);
      wait32(lat, bc);
      vectors++; if (lat != 33) begin miscompares++; $display("FAIL b2b_latency: got %0d want 33", lat); end
      vectors++; if (b32.q !== eq) begin miscompares++; $display("FAIL b2b_q: got %h want %h", b32.q, eq); end
      vectors++; if (b32.r !== er) begin miscompares++; $display("FAIL b2b_r: got %h want %h", b32.r, er); end
   endtask

   task automatic test_random32();
      logic [31:0] x, y, eq, er;
      int lat, bc, elat;
      for (int i = 0; i < 12; i++) begin
         x = $urandom();
         y = $urandom() >> $urandom_range(0, 31);
         if (i == 5) y = 32'd0;
         ref32(x, y, eq, er);
         elat = (y == 32'd0) ? 1 : 33;
         launch32(x, y);
         wait32(lat, bc);
         vectors++; if (lat != elat) begin miscompares++; $display("FAIL rand32_latency x=%h y=%h: got %0d want %0d", x, y, lat, elat); end
         vectors++; if (b32.q !== eq || b32.r !== er) begin miscompares++; $display("FAIL rand32_qr x=%h y=%h: got q=%h r=%h want q=%h r=%h", x, y, b32.q, b32.r, eq, er); end
      end
   endtask

   task automatic test_busy_ignore_and_reset();
      int n, dones;
      launch32(32'd100, 32'd7);
      n = 0;
      while (b32.done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 10) begin
            b32.start = 1'b1;
            b32.x = 32'd55;
            b32.y = 32'd5;
         end else begin
            b32.start = 1'b0;
         end
      end
      b32.start = 1'b0;
      vectors++; if (n != 33) begin miscompares++; $display("FAIL ignore_latency: got %0d want 33", n); end
      vectors++; if (b32.q !== 32'd14) begin miscompares++; $display("FAIL ignore_q: got %h want %h", b32.q, 32'd14); end
      vectors++; if (b32.r !== 32'd2) begin miscompares++; $display("FAIL ignore_r: got %h want 2", b32.r); end
      launch_now32(32'd1000, 32'd3);
      vectors++; if (b32.busy !== 1'b1) begin miscompares++; $display("FAIL done_cycle_start: got busy=%b want 1", b32.busy); end
      for (int i = 1; i < 20; i++) @(negedge clk);
      vectors++; if (b32.q !== 32'd14) begin miscompares++; $display("FAIL midrun_q_hold: got %h want %h", b32.q, 32'd14); end
      rst_n = 1'b0;
      #1;
      vectors++; if (b32.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", b32.busy); end
      vectors++; if (b32.q !== 32'h0) begin miscompares++; $display("FAIL abort_q: got %h want 0", b32.q); end
      vectors++; if (b32.r !== 32'h0) begin miscompares++; $display("FAIL abort_r: got %h want 0", b32.r); end
      vectors++; if (b32.done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b want 0", b32.done); end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b32.done === 1'b1) dones++;
      end
      vectors++; if (dones != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
   endtask

   task automatic test_sweep8();
      logic [7:0] ex [4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};
      logic [7:0] ey [4] = '{8'h01, 8'hFF, 8'h7F, 8'h80};
      logic [7:0] x, y, eq, er, chk;
      int lat;
      for (int i = 0; i < 416; i++) begin
         if (i < 16) begin
            x = ex[i / 4];
            y = ey[i % 4];
         end else begin
            x = 8'($urandom());
            y = 8'($urandom_range(1, 255));
         end
         ref8(x, y, eq, er);
         launch8(x, y);
         wait8(lat);
         chk = b8.q * y + b8.r;
         vectors++; if (lat != 9) begin miscompares++; $display("FAIL sweep8_latency x=%h y=%h: got %0d want 9", x, y, lat); end
         vectors++; if (b8.q !== eq) begin miscompares++; $display("FAIL sweep8_q x=%h y=%h: got %h want %h", x, y, b8.q, eq); end
         vectors++; if (b8.r !== er) begin miscompares++; $display("FAIL sweep8_r x=%h y=%h: got %h want %h", x, y, b8.r, er); end
         vectors++; if (chk !== x) begin miscompares++; $display("FAIL sweep8_identity x=%h y=%h: got %h want %h", x, y, chk, x); end
         vectors++; if (b8.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL sweep8_dbz x=%h y=%h: got %b want 0", x, y, b8.div_by_zero); end
      end
   endtask

   initial begin
      b32.start = 1'b0;
      b32.x = '0;
      b32.y = '0;
      b8.start = 1'b0;
      b8.x = '0;
      b8.y = '0;
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_back_to_back();
      test_random32();
      test_busy_ignore_and_reset();
      test_sweep8();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
